// File: rtl/step_decoder.sv
// step_decoder: registered step sequencer with programmable wrap and a
// registered one-hot decode gated by an output enable.
module step_decoder #(
   parameter int WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  EN,
   input  logic                  CLR,
   input  logic                  LOAD,
   input  logic [WIDTH-1:0]      S_IN,
   input  logic [WIDTH-1:0]      LAST,
   input  logic                  OE,
   output logic [WIDTH-1:0]      STEP,
   output logic [2**WIDTH-1:0]   T,
   output logic                  WRAP
);
   localparam int N = 2**WIDTH;
   localparam logic [N-1:0] ONEHOT_RST = {{(N-1){1'b0}}, 1'b1};
   logic [WIDTH-1:0] step_q, step_d;
   logic [N-1:0]     onehot_q, onehot_d;
   logic             wrap_q, wrap_d;
   logic             at_end;
   always_comb begin
      // Steps above LAST keep counting up to the top code before wrapping
      at_end   = (step_q == LAST) || (&step_q);
      step_d   = CLR ? '0 : LOAD ? S_IN : EN ? (at_end ? '0 : step_q + WIDTH'(1)) : step_q;
      wrap_d   = !CLR && !LOAD && EN && at_end;
      onehot_d = '0;
      onehot_d[step_d] = 1'b1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q   <= '0;
         onehot_q <= ONEHOT_RST;
         wrap_q   <= 1'b0;
      end else begin
         step_q   <= step_d;
         onehot_q <= onehot_d;
         wrap_q   <= wrap_d;
      end
   end
   assign STEP = step_q;
   assign WRAP = wrap_q;
   assign T    = OE ? onehot_q : '0;
endmodule

// File: tb/tb_step_decoder.sv
// tb_step_decoder: scoreboard bench for step_decoder (WIDTH=3); a reference
// model pushes expected state per edge, each test pops and compares.
module tb_step_decoder;
   logic       clk = 1'b0;
   logic       rst_n, EN, CLR, LOAD, OE;
   logic [2:0] S_IN, LAST;
   logic [2:0] STEP;
   logic [7:0] T;
   logic       WRAP;

   typedef struct {
      logic [2:0] step;
      logic       wrap;
   } exp_t;

   exp_t       sb[$];
   int         tests = 0;
   int         fails = 0;
   logic [2:0] m_step;
   logic       m_wrap;

   step_decoder #(.WIDTH(3)) dut (
      .clk(clk), .rst_n(rst_n), .EN(EN), .CLR(CLR), .LOAD(LOAD),
      .S_IN(S_IN), .LAST(LAST), .OE(OE), .STEP(STEP), .T(T), .WRAP(WRAP)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (OE) assert ($onehot(T)) else $error("T not one-hot: %h", T);

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [7:0] dec(input logic [2:0] s, input logic oe);
      logic [7:0] one;
      one = 8'h01;
      return oe ? (one << s) : 8'h00;
   endfunction

   // Drive one edge's inputs, advance the model, push its prediction.
   task automatic cyc(input logic en, input logic clr, input logic load,
                      input logic [2:0] s_in, input logic [2:0] last);
      exp_t e;
      @(negedge clk);
      EN = en; CLR = clr; LOAD = load; S_IN = s_in; LAST = last;
      if (clr) begin
         m_step = 3'd0; m_wrap = 1'b0;
      end else if (load) begin
         m_step = s_in; m_wrap = 1'b0;
      end else if (en) begin
         if (m_step == last || m_step == 3'd7) begin
            m_step = 3'd0; m_wrap = 1'b1;
         end else begin
            m_step = m_step + 3'd1; m_wrap = 1'b0;
         end
      end else m_wrap = 1'b0;
      e.step = m_step;
      e.wrap = m_wrap;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 3'd0, 3'd7);
         e = sb.pop_front();
         tests++;
         if (STEP !== e.step || WRAP !== e.wrap || T !== dec(e.step, OE)) begin
            fails++;
            $display("FAIL reset_pre cyc%0d: got STEP=%0d WRAP=%b T=%h, want STEP=%0d WRAP=%b T=%h",
                     i, STEP, WRAP, T, e.step, e.wrap, dec(e.step, OE));
         end
      end
      tests++;
      if (STEP !== 3'd5) begin
         fails++;
         $display("FAIL reset_pre_step: got %0d want 5", STEP);
      end
      @(negedge clk);
      EN = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (STEP !== 3'd0 || T !== 8'h01 || WRAP !== 1'b0) begin
         fails++;
         $display("FAIL reset_async: got STEP=%0d T=%h WRAP=%b, want 0 01 0", STEP, T, WRAP);
      end
      OE = 1'b0;
      #1;
      tests++;
      if (T !== 8'h00) begin
         fails++;
         $display("FAIL reset_oe0: got T=%h want 00", T);
      end
      OE = 1'b1;
      sb.delete();
      m_step = 3'd0;
      m_wrap = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 3'd0, 3'd7);
         e = sb.pop_front();
         tests++;
         if (STEP !== 3'd0 || T !== 8'h01 || WRAP !== 1'b0 || STEP !== e.step || WRAP !== e.wrap) begin
            fails++;
            $display("FAIL reset_hold cyc%0d: got STEP=%0d T=%h WRAP=%b, want 0 01 0", i, STEP, T, WRAP);
         end
      end
   endtask

   task automatic test_free_run;
      exp_t e;
      logic [2:0] want [12] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 3'd0, 3'd4);
         e = sb.pop_front();
         tests++;
         if (STEP !== e.step || STEP !== want[i] || WRAP !== (want[i] == 3'd0) || T !== dec(want[i], 1'b1)) begin
            fails++;
            $display("FAIL free_run cyc%0d: got STEP=%0d WRAP=%b T=%h, want STEP=%0d WRAP=%b T=%h",
                     i, STEP, WRAP, T, want[i], want[i] == 3'd0, dec(want[i], 1'b1));
         end
      end
   endtask

   task automatic test_load_beyond_last;
      exp_t e;
      logic [2:0] want_s [6] = '{6, 7, 0, 1, 2, 0};
      logic       want_w [6] = '{0, 0, 1, 0, 0, 1};
      for (int i = 0; i < 6; i++) begin
         if (i == 0) cyc(1'b0, 1'b0, 1'b1, 3'd6, 3'd2);
         else cyc(1'b1, 1'b0, 1'b0, 3'd0, 3'd2);
         e = sb.pop_front();
         tests++;
         if (STEP !== e.step || WRAP !== e.wrap || STEP !== want_s[i] || WRAP !== want_w[i] || T !== dec(want_s[i], 1'b1)) begin
            fails++;
            $display("FAIL load_beyond cyc%0d: got STEP=%0d WRAP=%b T=%h, want STEP=%0d WRAP=%b",
                     i, STEP, WRAP, T, want_s[i], want_w[i]);
         end
      end
   endtask

   task automatic test_priority;
      exp_t e;
      cyc(1'b0, 1'b0, 1'b1, 3'd3, 3'd7);
      e = sb.pop_front();
      tests++;
      if (STEP !== 3'd3 || STEP !== e.step) begin
         fails++;
         $display("FAIL prio_setup: got STEP=%0d want 3", STEP);
      end
      cyc(1'b1, 1'b1, 1'b1, 3'd5, 3'd7);
      e = sb.pop_front();
      tests++;
      if (STEP !== 3'd0 || WRAP !== 1'b0 || STEP !== e.step || WRAP !== e.wrap) begin
         fails++;
         $display("FAIL prio_clr: got STEP=%0d WRAP=%b want 0 0", STEP, WRAP);
      end
      cyc(1'b1, 1'b0, 1'b1, 3'd5, 3'd7);
      e = sb.pop_front();
      tests++;
      if (STEP !== 3'd5 || WRAP !== 1'b0 || STEP !== e.step) begin
         fails++;
         $display("FAIL prio_load: got STEP=%0d WRAP=%b want 5 0", STEP, WRAP);
      end
      cyc(1'b1, 1'b0, 1'b1, 3'd7, 3'd2);
      e = sb.pop_front();
      tests++;
      if (STEP !== 3'd7 || WRAP !== 1'b0 || STEP !== e.step) begin
         fails++;
         $display("FAIL prio_load_at_end: got STEP=%0d WRAP=%b want 7 0", STEP, WRAP);
      end
   endtask

   task automatic test_output_enable;
      exp_t e;
      cyc(1'b0, 1'b1, 1'b0, 3'd0, 3'd7);
      void'(sb.pop_front());
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 3'd0, 3'd7);
         OE = i[0];
         #1;
         e = sb.pop_front();
         tests++;
         if (STEP !== e.step || WRAP !== e.wrap || T !== dec(e.step, i[0])) begin
            fails++;
            $display("FAIL oe_toggle cyc%0d: got STEP=%0d T=%h, want STEP=%0d T=%h",
                     i, STEP, T, e.step, dec(e.step, i[0]));
         end
      end
      OE = 1'b1;
   endtask

   task automatic test_edge_last;
      exp_t e;
      int wraps;
      cyc(1'b0, 1'b1, 1'b0, 3'd0, 3'd0);
      void'(sb.pop_front());
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
         e = sb.pop_front();
         tests++;
         if (STEP !== 3'd0 || WRAP !== 1'b1 || T !== 8'h01 || WRAP !== e.wrap) begin
            fails++;
            $display("FAIL last0 cyc%0d: got STEP=%0d WRAP=%b T=%h, want 0 1 01", i, STEP, WRAP, T);
         end
      end
      wraps = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 3'd0, 3'd7);
         e = sb.pop_front();
         if (WRAP === 1'b1) wraps++;
         tests++;
         if (STEP !== 3'((i + 1) % 8) || STEP !== e.step || WRAP !== e.wrap || T !== dec(e.step, 1'b1)) begin
            fails++;
            $display("FAIL last7 cyc%0d: got STEP=%0d WRAP=%b T=%h, want STEP=%0d WRAP=%b",
                     i, STEP, WRAP, T, (i + 1) % 8, e.wrap);
         end
      end
      tests++;
      if (wraps != 2) begin
         fails++;
         $display("FAIL last7_wraps: got %0d wrap pulses want 2", wraps);
      end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 3'(7 - i), 3'd7);
         e = sb.pop_front();
         tests++;
         if (STEP !== 3'(7 - i) || STEP !== e.step || WRAP !== 1'b0 || T !== dec(3'(7 - i), 1'b1)) begin
            fails++;
            $display("FAIL b2b_load cyc%0d: got STEP=%0d T=%h want STEP=%0d", i, STEP, T, 7 - i);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; EN = 1'b0; CLR = 1'b0; LOAD = 1'b0; OE = 1'b1;
      S_IN = 3'd0; LAST = 3'd7;
      m_step = 3'd0; m_wrap = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_free_run();
      test_load_beyond_last();
      test_priority();
      test_output_enable();
      test_edge_last();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
